barrel_thread_scheduler: RTL
============================

// Module: barrel_thread_scheduler
// PURPOSE
//  Per-thread PC table and round-robin issue scheduler for the barrel-threaded RV32I core.
//  Replaces the fixed "one thread per stage" rotation.
//  - Threads may be masked off, halted, or kept in flight for any number of cycles.
//  - A thread is re-issued only after its writeback returns its next PC.
//  Sits between the fetch stage (consumes o_issue_*) and the writeback stage (drives i_wb_*).
// PARAMETERS
//  NUM_THREADS   16  number of hardware threads; power of two, 2..64
//  PC_WIDTH      12  width of the stored PC / instruction address
//  STARTUP_ADDR  0   PC loaded into every thread on reset (PC_WIDTH bits)
//  TID_W         $clog2(NUM_THREADS)  derived localparam; not overridable
// PORTS
//  clk           in   1            core clock
//  reset         in   1            asynchronous, active-high reset
//  i_thread_en   in   NUM_THREADS  per-thread enable mask; level-sensitive
//  i_stall       in   1            global hold of issue; writeback is still accepted
//  i_wb_valid    in   1            writeback for thread i_wb_tid this cycle
//  i_wb_tid      in   TID_W        thread id of the writeback
//  i_wb_next_pc  in   PC_WIDTH     next PC of that thread (branch/jump already resolved)
//  i_wb_halt     in   1            qualifies i_wb_valid: the thread executed ECALL/EBREAK and halts
//  o_issue_valid out  1            registered; a thread is issued to fetch this cycle
//  o_issue_tid   out  TID_W        registered thread id of the issue
//  o_issue_pc    out  PC_WIDTH     registered PC of the issue
//  o_busy        out  NUM_THREADS  per-thread in-flight flags (issued, writeback pending)
//  o_halted      out  NUM_THREADS  per-thread sticky halt flags
// BEHAVIOUR
//  Reset (async, active-high): all outputs, busy flags and halt flags are 0.
//  - Every PC table entry = STARTUP_ADDR.
//  - RR pointer = NUM_THREADS-1, so the first issue is the lowest enabled tid (tid 0 when enabled).
//  - Reset asserted mid-run drops all in-flight state.
//  - Writebacks arriving after reset release are ignored if the target thread is not busy.
//  Writeback (cycle n, i_wb_valid=1):
//  - pc[i_wb_tid] <= i_wb_next_pc; busy[i_wb_tid] <= 0.
//  - If i_wb_halt=1: halted[i_wb_tid] <= 1; the PC is still written.
//  - A writeback to a thread whose busy flag is 0 is ignored entirely; no state change.
//  Eligibility (combinational, cycle n):
//  - elig[t] = i_thread_en[t] & ~halted[t] & (~busy[t] | bypass[t]).
//  - bypass[t] = i_wb_valid & i_wb_tid==t & ~i_wb_halt.
//  - A bypassed thread issues with PC = i_wb_next_pc, not the table value.
//  - This gives back-to-back issue of one thread with zero bubble.
//  Selection: first eligible tid strictly after the RR pointer, modulo NUM_THREADS.
//  - Wrap-around: tid NUM_THREADS-1 is followed by tid 0.
//  Issue (cycle n, selection found and i_stall=0):
//  - busy[sel] <= 1; RR pointer <= sel.
//  - o_issue_valid/tid/pc <= 1/sel/pc_sel; outputs visible in cycle n+1 (latency 1).
//  - Same-tid writeback and issue in one cycle: busy ends at 1 and pc = wb value.
//  No eligible thread, or i_stall=1:
//  - o_issue_valid <= 0; o_issue_tid/pc hold their last values.
//  - RR pointer and busy flags unchanged, except for writeback clears.
//  Clearing i_thread_en[t] while busy[t]=1:
//  - the pending writeback is still accepted;
//  - the thread then stays idle until re-enabled and resumes at the stored PC.
//  Halt flags clear only on reset. Writebacks for different tids and the issue are independent.
// TESTING
//  1. Reset, en=16'hFFFF, each wb returned 16 cycles after issue with pc+4
//     -> tids 0..15 issued at PC 0, then tid 0 at PC 4, with no gaps.
//  2. en=16'h0005, no writebacks
//     -> issues tid0@0, tid2@0, then o_issue_valid=0 and o_busy=16'h0005.
//  3. en=16'h0001, wb tid0 every cycle with pc=pc+4 (bypass)
//     -> issue every cycle, PCs 0,4,8,... with no bubble.
//  4. wb tid3 with halt=1, next_pc=0x40
//     -> o_halted[3]=1 and pc[3]=0x40; tid3 is never issued again until reset.
//  5. i_stall held 5 cycles while wb tid1 arrives
//     -> no issue during stall, busy[1] cleared;
//     -> after release, RR continues from the tid after the last issued.
//  6. Reset pulsed with 4 threads busy, then stale wb for tid2
//     -> wb ignored; first issue is tid0@STARTUP_ADDR.

Source files
------------

// File: rtl/barrel_thread_scheduler.sv
// Per-thread PC table and round-robin issue scheduler for a barrel-threaded core.
// A thread is issued to fetch, stays busy until its writeback returns the next PC,
// and may be re-issued in the writeback cycle itself via the bypass path.
module barrel_thread_scheduler #(
  parameter int unsigned          NUM_THREADS  = 16,
  parameter int unsigned          PC_WIDTH     = 12,
  parameter logic [PC_WIDTH-1:0]  STARTUP_ADDR = '0,
  localparam int unsigned         TID_W        = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] i_thread_en,
  input  logic                   i_stall,
  input  logic                   i_wb_valid,
  input  logic [TID_W-1:0]       i_wb_tid,
  input  logic [PC_WIDTH-1:0]    i_wb_next_pc,
  input  logic                   i_wb_halt,
  output logic                   o_issue_valid,
  output logic [TID_W-1:0]       o_issue_tid,
  output logic [PC_WIDTH-1:0]    o_issue_pc,
  output logic [NUM_THREADS-1:0] o_busy,
  output logic [NUM_THREADS-1:0] o_halted
);

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [TID_W-1:0]       rr_q;

  logic                   wb_ok_c;
  logic [NUM_THREADS-1:0] bypass_c;
  logic [NUM_THREADS-1:0] elig_c;
  logic                   found_c;
  logic [TID_W-1:0]       sel_c;
  logic [PC_WIDTH-1:0]    sel_pc_c;
  logic                   issue_c;

  // Writeback acceptance (stale writebacks to idle threads are dropped) and eligibility
  always_comb begin
    wb_ok_c  = i_wb_valid & o_busy[i_wb_tid];
    bypass_c = '0;
    if (wb_ok_c && !i_wb_halt) begin
      bypass_c[i_wb_tid] = 1'b1;
    end
    elig_c = i_thread_en & ~o_halted & (~o_busy | bypass_c);
  end

  // Round-robin pick: first eligible tid strictly after the pointer, wrapping around
  always_comb begin
    logic [TID_W-1:0] cand;
    found_c = 1'b0;
    sel_c   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      cand = TID_W'(32'(rr_q) + k);
      if (!found_c && elig_c[cand]) begin
        found_c = 1'b1;
        sel_c   = cand;
      end
    end
    sel_pc_c = bypass_c[sel_c] ? i_wb_next_pc : pc_q[sel_c];
    issue_c  = found_c & ~i_stall;
  end

  // PC table: loaded from accepted writebacks only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= STARTUP_ADDR;
      end
    end else if (wb_ok_c) begin
      pc_q[i_wb_tid] <= i_wb_next_pc;
    end
  end

  // Busy/halt flags, RR pointer and registered issue outputs; issue wins over a same-tid clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_busy        <= '0;
      o_halted      <= '0;
      rr_q          <= TID_W'(NUM_THREADS - 1);
      o_issue_valid <= 1'b0;
      o_issue_tid   <= '0;
      o_issue_pc    <= '0;
    end else begin
      if (wb_ok_c) begin
        o_busy[i_wb_tid] <= 1'b0;
        if (i_wb_halt) begin
          o_halted[i_wb_tid] <= 1'b1;
        end
      end
      if (issue_c) begin
        o_busy[sel_c] <= 1'b1;
        rr_q          <= sel_c;
        o_issue_valid <= 1'b1;
        o_issue_tid   <= sel_c;
        o_issue_pc    <= sel_pc_c;
      end else begin
        o_issue_valid <= 1'b0;
      end
    end
  end

endmodule
